// File: rtl/clutter_ddr_cmd_exec.sv
// Memory-side executor for the clutter-map DDR FIFOs: pops one command at a time,
// streams write beats to the memory port, and returns read beats to the read FIFO.
module clutter_ddr_cmd_exec #(
    parameter int ADDR_W = 49,
    parameter int LEN_W  = 12,
    parameter int DATA_W = 128
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              cmd_empty,
    input  logic [63:0]       cmd_dout,
    output logic              cmd_rd_en,
    input  logic              wr_empty,
    input  logic [DATA_W-1:0] wr_dout,
    output logic              wr_rd_en,
    input  logic              rd_full,
    output logic              rd_wr_en,
    output logic [DATA_W-1:0] rd_din,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_rnw,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_last,
    input  logic              mem_rdata_valid,
    output logic              mem_rdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_last,
    output logic              busy,
    output logic [15:0]       cmd_done_cnt,
    output logic              err_len,
    output logic              err_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        CMD   = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               rnw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [15:0]        done_q, done_d;
    logic [LEN_W-1:0]   len_m1;
    logic               is_last;
    logic               unused_rsvd;

    // Reserved command bits carry no meaning for the executor.
    assign unused_rsvd = ^cmd_dout[62:61];

    assign len_m1       = len_q - {{(LEN_W-1){1'b0}}, 1'b1};
    assign is_last      = (beat_q == len_m1);
    assign busy         = (state_q != IDLE);
    assign cmd_done_cnt = done_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            if (cmd_rd_en) begin
                rnw_q  <= cmd_dout[63];
                addr_q <= cmd_dout[LEN_W +: ADDR_W];
                len_q  <= cmd_dout[LEN_W-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        done_d          = done_q;
        cmd_rd_en       = 1'b0;
        wr_rd_en        = 1'b0;
        rd_wr_en        = 1'b0;
        rd_din          = '0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_rnw     = 1'b0;
        mem_cmd_addr    = '0;
        mem_cmd_len     = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        mem_wdata_last  = 1'b0;
        mem_rdata_ready = 1'b0;
        err_len         = 1'b0;
        err_last        = 1'b0;

        case (state_q)
            IDLE: begin
                // Gating with rst_n keeps the pop strobe low while reset is held.
                if (!cmd_empty && rst_n) begin
                    cmd_rd_en = 1'b1;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                if (len_q == '0) begin
                    err_len = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CMD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_rnw   = rnw_q;
                mem_cmd_addr  = addr_q;
                mem_cmd_len   = len_q;
                if (mem_cmd_ready) begin
                    beat_d  = '0;
                    state_d = rnw_q ? RDATA : WDATA;
                end
            end
            WDATA: begin
                mem_wdata_valid = !wr_empty;
                mem_wdata       = wr_dout;
                mem_wdata_last  = is_last && !wr_empty;
                if (!wr_empty && mem_wdata_ready) begin
                    wr_rd_en = 1'b1;
                    beat_d   = beat_q + 1'b1;
                    if (is_last) begin
                        done_d  = done_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            RDATA: begin
                mem_rdata_ready = !rd_full;
                rd_din          = mem_rdata;
                // Beat count alone ends the burst; the memory's last flag is only audited.
                if (mem_rdata_valid && !rd_full) begin
                    rd_wr_en = 1'b1;
                    err_last = (mem_rdata_last != is_last);
                    beat_d   = beat_q + 1'b1;
                    if (is_last) begin
                        done_d  = done_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
